// File: rtl/ms_result_bcd.sv
// ms_result_bcd: converts the signed multiplier product to packed BCD with a
// sequential double-dabble engine (one shift per clock). It then drives
// active-low 7-segment patterns with leading-zero blanking and a minus sign.
module ms_result_bcd #(
    parameter int DW = 17,
    parameter int ND = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DW-1:0]     i_data,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_neg,
    output logic [4*ND-1:0]   o_bcd,
    output logic [7*ND-1:0]   o_seg,
    output logic [6:0]        o_sign_seg
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [DW-1:0]     held;
    logic [DW-1:0]     mag;
    logic              neg_q;
    logic [4*ND-1:0]   scratch;
    logic [CW-1:0]     cnt;

    logic [4*ND-1:0]   bcd_adj;
    logic [4*ND-1:0]   bcd_shifted;
    logic [7*ND-1:0]   seg_next;
    logic [6:0]        sign_next;

    // Active-low gfedcba pattern for one decimal digit; non-digits show blank.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_to_seg = 7'b1000000;
            4'd1:    digit_to_seg = 7'b1111001;
            4'd2:    digit_to_seg = 7'b0100100;
            4'd3:    digit_to_seg = 7'b0110000;
            4'd4:    digit_to_seg = 7'b0011001;
            4'd5:    digit_to_seg = 7'b0010010;
            4'd6:    digit_to_seg = 7'b0000010;
            4'd7:    digit_to_seg = 7'b1111000;
            4'd8:    digit_to_seg = 7'b0000000;
            4'd9:    digit_to_seg = 7'b0010000;
            default: digit_to_seg = 7'b1111111;
        endcase
    endfunction

    // State register; reset drops straight back to idle, aborting any conversion.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the shift phase lasts exactly DW clocks, one per input bit.
    always_comb begin
        next_state = state;
        o_ready    = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt == CW'(DW - 1)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Double-dabble step: correct every nibble of 5 or more, then shift in the next magnitude bit.
    always_comb begin
        bcd_adj = scratch;
        for (int i = 0; i < ND; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        bcd_shifted = {bcd_adj[4*ND-2:0], mag[DW-1]};
    end

    // Display patterns: blank every digit above the most significant nonzero one, but always show digit 0.
    always_comb begin : seg_build
        logic seen_nonzero;
        seen_nonzero = 1'b0;
        seg_next     = '1;
        for (int i = ND - 1; i >= 0; i--) begin
            if (scratch[4*i +: 4] != 4'd0) begin
                seen_nonzero = 1'b1;
            end
            if (seen_nonzero || (i == 0)) begin
                seg_next[7*i +: 7] = digit_to_seg(scratch[4*i +: 4]);
            end
        end
        sign_next = (neg_q && (scratch != '0)) ? 7'b0111111 : 7'h7F;
    end

    // Conversion datapath: capture, take magnitude, then shift DW times.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            held    <= '0;
            mag     <= '0;
            neg_q   <= 1'b0;
            scratch <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        held <= i_data;
                    end
                end
                ST_LOAD: begin
                    mag     <= held[DW-1] ? -held : held;
                    neg_q   <= held[DW-1];
                    scratch <= '0;
                    cnt     <= '0;
                end
                ST_SHIFT: begin
                    scratch <= bcd_shifted;
                    mag     <= {mag[DW-2:0], 1'b0};
                    cnt     <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers change only on the done edge, so the display never shows partial results.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_done     <= 1'b0;
            o_neg      <= 1'b0;
            o_bcd      <= '0;
            o_seg      <= '1;
            o_sign_seg <= 7'h7F;
        end else begin
            o_done <= 1'b0;
            if (state == ST_DONE) begin
                o_done     <= 1'b1;
                o_neg      <= neg_q;
                o_bcd      <= scratch;
                o_seg      <= seg_next;
                o_sign_seg <= sign_next;
            end
        end
    end

endmodule

// File: tb/tb_ms_result_bcd.sv
// tb_ms_result_bcd: drives ms_result_bcd with directed and random products and
// compares the outputs against a decimal-arithmetic model of the display.
module tb_ms_result_bcd;

    localparam int DW = 17;
    localparam int ND = 5;

    logic              i_clk;
    logic              i_rst;
    logic              i_start;
    logic [DW-1:0]     i_data;
    logic              o_ready;
    logic              o_done;
    logic              o_neg;
    logic [4*ND-1:0]   o_bcd;
    logic [7*ND-1:0]   o_seg;
    logic [6:0]        o_sign_seg;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    ms_result_bcd #(.DW(DW), .ND(ND)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_done     (o_done),
        .o_neg      (o_neg),
        .o_bcd      (o_bcd),
        .o_seg      (o_seg),
        .o_sign_seg (o_sign_seg)
    );

    // Free-running 100 MHz clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    // Reference: decimal digits by repeated division, display by digit count.
    task automatic checkResult(input logic [DW-1:0] d, input string tag);
        int sv;
        int magv;
        int rem;
        int ndig;
        logic [4*ND-1:0] exp_bcd;
        logic [7*ND-1:0] exp_seg;
        logic [6:0]      exp_sign;
        logic            exp_neg;
        sv      = $signed(d);
        exp_neg = (sv < 0);
        magv    = exp_neg ? -sv : sv;
        rem     = magv;
        ndig    = 0;
        exp_bcd = '0;
        exp_seg = '1;
        for (int i = 0; i < ND; i++) begin
            exp_bcd[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        rem = magv;
        do begin
            ndig++;
            rem = rem / 10;
        end while (rem != 0);
        for (int i = 0; i < ndig; i++) begin
            exp_seg[7*i +: 7] = seg_tab[int'(exp_bcd[4*i +: 4])];
        end
        exp_sign = (exp_neg && magv != 0) ? 7'b0111111 : 7'h7F;
        checkOutput({tag, "_bcd"},  64'(o_bcd),      64'(exp_bcd));
        checkOutput({tag, "_neg"},  64'(o_neg),      64'(exp_neg));
        checkOutput({tag, "_seg"},  64'(o_seg),      64'(exp_seg));
        checkOutput({tag, "_sign"}, 64'(o_sign_seg), 64'(exp_sign));
    endtask

    // One conversion: start pulse, optional busy re-pulse, latency/ready/one-shot checks, then result check.
    task automatic applyStimulus(input logic [DW-1:0] d, input string tag,
                                 input int poke_at, input logic [DW-1:0] poke_data);
        int n;
        int ready_low;
        bit got;
        checkOutput({tag, "_ready_pre"}, 64'(o_ready), 64'd1);
        i_data  = d;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start   = 1'b0;
        ready_low = (o_ready == 1'b0) ? 1 : 0;
        got       = 1'b0;
        for (n = 1; n <= 40; n++) begin
            if (n == poke_at) begin
                i_start = 1'b1;
                i_data  = poke_data;
            end else begin
                i_start = 1'b0;
            end
            @(posedge i_clk);
            #1;
            if (o_done) begin
                got = 1'b1;
                break;
            end
            if (o_ready == 1'b0) ready_low++;
        end
        i_start = 1'b0;
        checkOutput({tag, "_latency"},   64'(got ? n : 99), 64'd19);
        checkOutput({tag, "_ready_low"}, 64'(ready_low),    64'd19);
        checkOutput({tag, "_ready_done"}, 64'(o_ready),     64'd1);
        checkResult(d, tag);
        @(posedge i_clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        int spurious;
        int pulses;
        int last;
        int glitches;
        logic [DW-1:0] r;

        i_rst   = 1'b0;
        i_start = 1'b0;
        i_data  = '0;
        #23;
        checkOutput("rst_ready", 64'(o_ready),    64'd1);
        checkOutput("rst_done",  64'(o_done),     64'd0);
        checkOutput("rst_neg",   64'(o_neg),      64'd0);
        checkOutput("rst_bcd",   64'(o_bcd),      64'd0);
        checkOutput("rst_seg",   64'(o_seg),      64'h7_FFFF_FFFF);
        checkOutput("rst_sign",  64'(o_sign_seg), 64'h7F);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        applyStimulus(17'd294,   "t1_294",   0, '0);
        checkOutput("t1_bcd_lit", 64'(o_bcd), 64'h00294);
        applyStimulus(17'h1FEDA, "t2_m294",  0, '0);
        applyStimulus(17'd0,     "t3_zero",  0, '0);
        applyStimulus(17'h10000, "t3_min",   0, '0);
        checkOutput("t3_min_lit", 64'(o_bcd), 64'h65536);
        applyStimulus(17'h0FFFF, "t3_max",   0, '0);

        applyStimulus(17'd240, "t4_busy", 5, 17'd3200);
        spurious = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge i_clk);
            #1;
            if (o_done) spurious++;
        end
        checkOutput("t4_no_second_done", 64'(spurious), 64'd0);
        checkOutput("t4_held_result",    64'(o_bcd),    64'h00240);

        i_data  = 17'd294;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge i_clk);
            #1;
            if (o_done) spurious++;
        end
        i_rst = 1'b0;
        #1;
        checkOutput("t5_rst_ready", 64'(o_ready),    64'd1);
        checkOutput("t5_rst_bcd",   64'(o_bcd),      64'd0);
        checkOutput("t5_rst_seg",   64'(o_seg),      64'h7_FFFF_FFFF);
        checkOutput("t5_rst_sign",  64'(o_sign_seg), 64'h7F);
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk);
            #1;
            if (o_done) spurious++;
        end
        checkOutput("t5_no_done", 64'(spurious), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        applyStimulus(17'd3200, "t5_after", 0, '0);

        i_data   = 17'd294;
        i_start  = 1'b1;
        pulses   = 0;
        last     = -1;
        glitches = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge i_clk);
            #1;
            if (o_done) begin
                if (last >= 0) checkOutput("t6_period", 64'(c - last), 64'd20);
                last = c;
                pulses++;
            end
            if (pulses > 0 && o_bcd !== 20'h00294) glitches++;
        end
        i_start = 1'b0;
        checkOutput("t6_pulses",   64'(pulses),   64'd5);
        checkOutput("t6_glitches", 64'(glitches), 64'd0);
        for (int c = 0; c < 25; c++) begin
            @(posedge i_clk);
            #1;
        end

        for (int k = 0; k < 20; k++) begin
            r = DW'($urandom);
            applyStimulus(r, $sformatf("rnd%0d", k), 0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
